prefetch_line_packer: RTL

PREFETCH_LINE_PACKER -- requirements
Module: prefetch_line_packer

---
 rtl/prefetch_line_packer_pkg.sv | 25 ++
 rtl/prefetch_line_align.sv | 29 ++
 rtl/prefetch_line_packer.sv | 103 ++++++++++
 3 files changed

// File: rtl/prefetch_line_packer_pkg.sv
// Shared ao486 prefetch defines: state encoding, line geometry, FIFO threshold
// and the packed pair layout written into the prefetch FIFO.
package prefetch_line_packer_pkg;

    localparam int LINE_BYTES      = 16;
    localparam int HALF_BYTES      = 8;
    localparam int FIFO_HIGH_WATER = 13;

    localparam logic [1:0] PREFETCH_GP_FAULT = 2'd1;
    localparam logic [1:0] PREFETCH_PF_FAULT = 2'd2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LIMIT_PEND = 2'd1,
        STOP       = 2'd2
    } pf_state_t;

    typedef struct packed {
        logic [3:0]  len_hi;
        logic [63:0] data_hi;
        logic [3:0]  len_lo;
        logic [63:0] data_lo;
    } fifo_pair_t;

endpackage

// File: rtl/prefetch_line_align.sv
// Combinational shift/mask/length unit: drops the bytes before the offset,
// keeps the first len bytes and splits them into the two FIFO halves.
module prefetch_line_align
    import prefetch_line_packer_pkg::*;
(
    input  logic [127:0] line_data,
    input  logic [3:0]   offset,
    input  logic [4:0]   len,
    output fifo_pair_t   pair
);

    logic [127:0] shifted;
    logic [127:0] masked;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shifted = line_data >> {offset, 3'b000};
        masked  = '0;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (5'(k) < len) masked[8*k +: 8] = shifted[8*k +: 8];
        end
        pair.data_lo = masked[63:0];
        pair.data_hi = masked[127:64];
        pair.len_lo  = (len > 5'(HALF_BYTES)) ? 4'(HALF_BYTES) : len[3:0];
        pair.len_hi  = (len > 5'(HALF_BYTES)) ? 4'(len - 5'(HALF_BYTES)) : 4'd0;
    end

endmodule

// File: rtl/prefetch_line_packer.sv
// Accepts fetched code lines, packs the wanted bytes into FIFO pairs and
// reports CS-limit and page faults as one-cycle strobes.
module prefetch_line_packer
    import prefetch_line_packer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pr_reset,
    input  logic         line_valid,
    output logic         line_ready,
    input  logic [127:0] line_data,
    input  logic [3:0]   line_offset,
    input  logic [4:0]   line_limit_len,
    input  logic         pf_fault_do,
    input  logic [4:0]   prefetchfifo_used,
    output logic         prefetchfifo_write_do,
    output logic [135:0] prefetchfifo_write_data,
    output logic         prefetchfifo_signal_limit_do,
    output logic         prefetchfifo_signal_pf_do
);

    pf_state_t    state, state_next;
    logic         write_next, limit_next, pf_next;
    logic [135:0] data_next;

    logic [4:0]   sat_len, avail, n;
    logic         limit_hit, accept;
    fifo_pair_t   pair;

    always_comb begin
        sat_len   = (line_limit_len > 5'(LINE_BYTES)) ? 5'(LINE_BYTES) : line_limit_len;
        avail     = 5'(LINE_BYTES) - {1'b0, line_offset};
        limit_hit = sat_len < avail;
        n         = limit_hit ? sat_len : avail;
    end

    // Ready drops with rst_n directly so nothing is taken while in reset.
    assign line_ready = rst_n && (state == RUN) && !pr_reset && !pf_fault_do
                        && (prefetchfifo_used <= 5'(FIFO_HIGH_WATER));
    assign accept     = line_valid && line_ready;

    prefetch_line_align u_align (
        .line_data (line_data),
        .offset    (line_offset),
        .len       (n),
        .pair      (pair)
    );

    always_comb begin
        state_next = state;
        write_next = 1'b0;
        limit_next = 1'b0;
        pf_next    = 1'b0;
        data_next  = prefetchfifo_write_data;
        if (pr_reset) begin
            state_next = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (pf_fault_do) begin
                        pf_next    = 1'b1;
                        state_next = STOP;
                    end else if (accept) begin
                        if (n != 5'd0) begin
                            write_next = 1'b1;
                            data_next  = pair;
                            state_next = limit_hit ? LIMIT_PEND : RUN;
                        end else begin
                            limit_next = 1'b1;
                            state_next = STOP;
                        end
                    end
                end
                // The last partial line was just written; the limit fault follows it.
                LIMIT_PEND: begin
                    limit_next = 1'b1;
                    state_next = STOP;
                end
                STOP:    state_next = STOP;
                default: state_next = RUN;
            endcase
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the values computed before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                        <= RUN;
            prefetchfifo_write_do        <= 1'b0;
            prefetchfifo_signal_limit_do <= 1'b0;
            prefetchfifo_signal_pf_do    <= 1'b0;
            prefetchfifo_write_data      <= '0;
        end else begin
            state                        <= state_next;
            prefetchfifo_write_do        <= write_next;
            prefetchfifo_signal_limit_do <= limit_next;
            prefetchfifo_signal_pf_do    <= pf_next;
            prefetchfifo_write_data      <= data_next;
        end
    end

endmodule
